// File: rtl/img_pkg.sv
// Shared frame geometry, pixel format and writer FSM state type for the frame BRAM
// write side and the VGA display path.
package img_pkg;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int PIX_NUM    = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } img_state_t;

    // RGB444 assembly from a red nibble and a {G,B} byte
    function automatic logic [DATA_W-1:0] pack_rgb(input logic [3:0] red, input logic [7:0] gb);
        return {red, gb};
    endfunction

endpackage

// File: rtl/img_byte_packer.sv
// Pairs 8-bit input bytes into one RGB444 pixel beat: byte 0 (may carry sof) gives R,
// byte 1 gives {G,B}. A sof on byte 1 flags an error and restarts the pair.
module img_byte_packer
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic              i_sof,
    input  logic [7:0]        i_byte,
    output logic              o_valid,
    output logic              o_sof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    logic       r_phase;
    logic [3:0] r_red;
    logic       r_sof;

    // Byte-phase register: a sof always (re)starts a pair as byte 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_red   <= 4'h0;
            r_sof   <= 1'b0;
        end else if (i_accept) begin
            if (!r_phase || i_sof) begin
                r_phase <= 1'b1;
                r_red   <= i_byte[3:0];
                r_sof   <= i_sof;
            end else begin
                r_phase <= 1'b0;
            end
        end
    end

    assign o_valid = i_accept && r_phase && !i_sof;
    assign o_err   = i_accept && r_phase && i_sof;
    assign o_sof   = r_sof;
    assign o_data  = pack_rgb(r_red, i_byte);

endmodule

// File: rtl/img_bram_writer.sv
// Raster-order writer of an RGB444 pixel stream into the frame BRAM, with frame-done and
// framing-error pulses. Define IMG_WR_BYTE_IN_EN for an 8-bit, two-bytes-per-pixel input.
module img_bram_writer
    import img_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int AW     = ADDR_W,
    parameter int DW     = DATA_W
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          pix_sof,
    input  logic          pix_valid,
`ifdef IMG_WR_BYTE_IN_EN
    input  logic [7:0]    pix_data,
`else
    input  logic [DW-1:0] pix_data,
`endif
    output logic          pix_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          frame_done,
    output logic          frame_err,
    output logic          busy
);

    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    img_state_t    r_state;
    img_state_t    w_nxt_state;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_nxt_cnt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_done;
    logic          r_err;
    logic          r_busy;

    logic          w_accept;
    logic          w_beat_valid;
    logic          w_beat_sof;
    logic [DW-1:0] w_beat_data;
    logic          w_pk_err;
    logic          w_wr;
    logic [AW-1:0] w_wr_addr;
    logic          w_err;
    logic          w_done;

    assign pix_ready = (r_state != DONE);
    assign w_accept  = pix_valid && pix_ready;

`ifdef IMG_WR_BYTE_IN_EN
    img_byte_packer u_packer (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_sof    (pix_sof),
        .i_byte   (pix_data),
        .o_valid  (w_beat_valid),
        .o_sof    (w_beat_sof),
        .o_data   (w_beat_data),
        .o_err    (w_pk_err)
    );
`else
    assign w_beat_valid = w_accept;
    assign w_beat_sof   = pix_sof;
    assign w_beat_data  = pix_data;
    assign w_pk_err     = 1'b0;
`endif

    // Next-state and write decode; a sof beat always lands at address 0
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_wr        = 1'b0;
        w_wr_addr   = r_cnt;
        w_err       = w_pk_err;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat_valid && w_beat_sof) begin
                    w_wr      = 1'b1;
                    w_wr_addr = '0;
                end else begin
                    w_wr = 1'b0;
                end
            end
            WRITE: begin
                if (w_beat_valid) begin
                    w_wr = 1'b1;
                    if (w_beat_sof) begin
                        w_wr_addr = '0;
                        w_err     = w_pk_err || (r_cnt != '0);
                    end else begin
                        w_wr_addr = r_cnt;
                    end
                end else begin
                    w_wr = 1'b0;
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
        if (w_wr) begin
            if (w_wr_addr == LAST_ADDR) begin
                w_nxt_state = DONE;
                w_nxt_cnt   = '0;
                w_done      = 1'b1;
            end else begin
                w_nxt_state = WRITE;
                w_nxt_cnt   = w_wr_addr + AW'(1);
            end
        end else begin
            w_done = 1'b0;
        end
    end

    // State, counter and registered BRAM/status outputs; address/data hold between writes
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_we    <= w_wr;
            if (w_wr) begin
                r_waddr <= w_wr_addr;
                r_wdata <= w_beat_data;
            end
            r_done  <= w_done;
            r_err   <= w_err;
            r_busy  <= (w_nxt_state == WRITE);
        end
    end

    assign ram_we     = r_we;
    assign ram_waddr  = r_waddr;
    assign ram_wdata  = r_wdata;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_img_bram_writer.sv
// Self-checking bench for img_bram_writer on a reduced 40x30 frame; every cycle is compared
// against a frame-level reference model. Honours IMG_WR_BYTE_IN_EN for the byte-input build.
module tb_img_bram_writer;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int PIX = W * H;
`ifdef IMG_WR_BYTE_IN_EN
    localparam int PD  = 8;
`else
    localparam int PD  = 12;
`endif

    logic          vga_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [PD-1:0] pix_data = '0;
    logic          pix_ready, ram_we, frame_done, frame_err, busy;
    logic [16:0]   ram_waddr;
    logic [11:0]   ram_wdata;

    img_bram_writer #(.WIDTH(W), .HEIGHT(H), .AW(17), .DW(12)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_err = 0;
    int n_dut_done = 0;
    bit armed = 1'b0;

    // reference model: frame position plus byte pairing, and expected next outputs
    bit m_in_frame, m_done_cyc, m_bph, m_bsof;
    int m_pos;
    logic [3:0] m_red;
    logic e_we, e_done, e_err, e_busy;
    logic [16:0] e_addr;
    logic [11:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_pix(input bit s, input logic [11:0] px);
        bit wr;
        int a;
        wr = 1'b0;
        a = 0;
        if (s) begin
            if (m_in_frame) e_err = 1'b1;
            wr = 1'b1;
            a = 0;
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            wr = 1'b1;
            a = m_pos;
        end
        if (wr) begin
            e_we = 1'b1;
            e_addr = 17'(a);
            e_data = px;
            if (a == PIX - 1) begin
                m_in_frame = 1'b0;
                m_pos = 0;
                m_done_cyc = 1'b1;
                e_done = 1'b1;
            end else begin
                m_pos = a + 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit s, input logic [PD-1:0] d, output bit acc);
        if (armed) begin
            chk("pix_ready", {31'd0, pix_ready}, {31'd0, !m_done_cyc});
            chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
            chk("ram_waddr", {15'd0, ram_waddr}, {15'd0, e_addr});
            chk("ram_wdata", {20'd0, ram_wdata}, {20'd0, e_data});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e_err});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            if (frame_done === 1'b1) n_dut_done++;
        end
        rst_n = !rst;
        pix_valid = v;
        pix_sof = s;
        pix_data = d;
        acc = 1'b0;
        e_we = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0; m_done_cyc = 1'b0; m_pos = 0;
            m_bph = 1'b0; m_bsof = 1'b0; m_red = 4'h0;
            e_addr = 17'd0; e_data = 12'd0;
            armed = 1'b1;
        end else if (m_done_cyc) begin
            m_done_cyc = 1'b0;
        end else if (v) begin
            acc = 1'b1;
`ifdef IMG_WR_BYTE_IN_EN
            if (!m_bph || s) begin
                if (m_bph) e_err = 1'b1;
                m_red = d[3:0];
                m_bsof = s;
                m_bph = 1'b1;
            end else begin
                m_bph = 1'b0;
                model_pix(m_bsof, {m_red, d[7:0]});
            end
`else
            model_pix(s, d);
`endif
        end
        e_busy = m_in_frame;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic send_unit(input bit s, input logic [PD-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 3 && !acc; k++) step(1'b0, 1'b1, s, d, acc);
        if (!acc) chk("accept_bound", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_pix(input bit s, input logic [11:0] px);
`ifdef IMG_WR_BYTE_IN_EN
        send_unit(s, {4'h0, px[11:8]});
        send_unit(1'b0, px[7:0]);
`else
        send_unit(s, px);
`endif
    endtask

    initial begin
        bit acc;
        step(1'b1, 1'b0, 1'b0, '0, acc);
        step(1'b1, 1'b0, 1'b0, '0, acc);
        idle(2);

        // pre-sof junk is dropped, then a full frame with data = address
        for (int i = 0; i < 5; i++) send_pix(1'b0, 12'($urandom));
        send_pix(1'b1, 12'h000);
        chk("first_addr", {15'd0, ram_waddr}, 32'd0);
        for (int i = 1; i < PIX; i++) send_pix(1'b0, 12'(i));
        idle(3);
        chk("frames_after_full", n_dut_done, 32'd1);

        // mid-frame sof at beat 1000 restarts the frame
        send_pix(1'b1, 12'($urandom));
        for (int i = 1; i < 1000; i++) send_pix(1'b0, 12'($urandom));
        send_pix(1'b1, 12'h5A5);
        chk("restart_err", {31'd0, frame_err}, 32'd1);
        chk("restart_addr", {15'd0, ram_waddr}, 32'd0);
        chk("restart_data", {20'd0, ram_wdata}, 32'h5A5);
        for (int i = 1; i < PIX; i++) send_pix(1'b0, 12'($urandom));
        idle(3);
        chk("frames_after_restart", n_dut_done, 32'd2);

        // gapped frame
        send_pix(1'b1, 12'($urandom));
        for (int i = 1; i < PIX; i++) begin
            idle(1);
            send_pix(1'b0, 12'($urandom));
        end
        idle(3);
        chk("frames_after_gaps", n_dut_done, 32'd3);

        // reset mid-frame, then a clean frame
        send_pix(1'b1, 12'($urandom));
        for (int i = 1; i < 600; i++) send_pix(1'b0, 12'($urandom));
        step(1'b1, 1'b0, 1'b0, '0, acc);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_we", {31'd0, ram_we}, 32'd0);
        send_pix(1'b1, 12'($urandom));
        for (int i = 1; i < PIX; i++) send_pix(1'b0, 12'($urandom));
        idle(3);
        chk("frames_after_reset", n_dut_done, 32'd4);

`ifdef IMG_WR_BYTE_IN_EN
        // byte pairing and sof on the second byte
        send_unit(1'b1, 8'h0A);
        send_unit(1'b0, 8'hBC);
        chk("byte_we", {31'd0, ram_we}, 32'd1);
        chk("byte_addr", {15'd0, ram_waddr}, 32'd0);
        chk("byte_data", {20'd0, ram_wdata}, 32'hABC);
        send_unit(1'b1, 8'h01);
        send_unit(1'b1, 8'h02);
        chk("byte_sof_err", {31'd0, frame_err}, 32'd1);
        step(1'b1, 1'b0, 1'b0, '0, acc);
        idle(2);
`endif

        // randomized traffic with rare sof and rare reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) == 0, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1999) == 0, PD'($urandom), acc);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
